// File: rtl/io_pkg.sv
// Shared types and defaults for the board-level input controller.
package io_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } io_state_e;

    localparam int unsigned IO_DEBOUNCE_DEFAULT = 500000;
    localparam int unsigned IO_SW_WIDTH_DEFAULT = 10;
    localparam int unsigned IO_DATA_WIDTH       = 32;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low key.
// key is the synchronized level (1 = pressed); key_db is the accepted level.
module io_debounce
    import io_pkg::*;
#(
    parameter int unsigned CYCLES = IO_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic key,
    output logic key_db
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    assign key = ~sync2;

    // Synchronizer flops reset to the released (high) level of the raw key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            cnt    <= '0;
            key_db <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            sync1 <= raw_n;
            sync2 <= sync1;
            if (key == key_db) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES)) begin
                key_db <= key;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_ctrl.sv
// Switch/Enter front end: debounced press captures a switch snapshot for the CPU.
// Define IO_INPUT_SIGNED_EN to sign-extend in_data from the top switch bit.
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter int unsigned SW_WIDTH        = IO_SW_WIDTH_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     enter_n,
    input  logic [SW_WIDTH-1:0]      sw_raw,
    input  logic                     in_req,
    output logic                     in_valid,
    output logic [IO_DATA_WIDTH-1:0] in_data,
    output logic                     pending
);

    // Samples of released key needed before arming; the extra two cover the
    // synchronizer flops, which read "released" straight out of reset.
    localparam int unsigned REL_SAMPLES = DEBOUNCE_CYCLES + 2;
    localparam int unsigned RW          = $clog2(REL_SAMPLES + 1);

    logic                     key, key_db;
    logic [SW_WIDTH-1:0]      sw_s1, sw_s2, snapshot;
    logic [RW-1:0]            rel_cnt;
    logic [IO_DATA_WIDTH-1:0] snap_ext;
    io_state_e                state;

    io_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk    (CLK),
        .rst_n  (reset),
        .raw_n  (enter_n),
        .key    (key),
        .key_db (key_db)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
        end
    end

    always_comb begin
        // NOTE: default first so no bit of snap_ext is left unassigned (no latch).
        snap_ext = '0;
        for (int i = 0; i < int'(SW_WIDTH); i++) snap_ext[i] = snapshot[i];
`ifdef IO_INPUT_SIGNED_EN
        for (int i = int'(SW_WIDTH); i < int'(IO_DATA_WIDTH); i++) snap_ext[i] = snapshot[SW_WIDTH-1];
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= RELEASE;
            rel_cnt  <= '0;
            // NOTE: the snapshot is a plain register, so it is reset like any other flop.
            snapshot <= '0;
            pending  <= 1'b0;
            in_valid <= 1'b0;
            in_data  <= '0;
        end else begin
            in_valid <= 1'b0;
            if (pending && in_req) begin
                in_valid <= 1'b1;
                in_data  <= snap_ext;
                pending  <= 1'b0;
            end

            // A press accepted on the consume edge re-sets pending below.
            case (state)
                RELEASE: begin
                    if (key_db || key) begin
                        rel_cnt <= '0;
                    end else if (rel_cnt == RW'(REL_SAMPLES - 1)) begin
                        rel_cnt <= '0;
                        state   <= ARM;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                ARM: begin
                    if (key_db) begin
                        snapshot <= sw_s2;
                        pending  <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!key_db) state <= ARM;
                end
                default: state <= RELEASE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: randomized presses/requests vs an operation-level model.
module tb_io_input_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned SW = 10;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          enter_n = 1'b1;
    logic [SW-1:0] sw_raw = '0;
    logic          in_req = 1'b0;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the captured-but-unconsumed value, latest press wins.
    bit            model_pending = 1'b0;
    logic [SW-1:0] model_snap = '0;
    logic [31:0]   exp_q[$];
    logic          prev_valid = 1'b0;

    io_input_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .SW_WIDTH        (SW)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .enter_n  (enter_n),
        .sw_raw   (sw_raw),
        .in_req   (in_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .pending  (pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] extend(input logic [SW-1:0] v);
`ifdef IO_INPUT_SIGNED_EN
        return 32'(signed'(v));
`else
        return 32'(v);
`endif
    endfunction

    // Monitor: every in_valid pulse pops one expected value.
    always @(negedge CLK) begin
        if (in_valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_valid", {31'd0, in_valid}, 32'd0);
            else check("in_data", in_data, exp_q.pop_front());
        end
        prev_valid = in_valid;
    end

    task automatic press(input logic [SW-1:0] sw, input int hold);
        @(negedge CLK);
        sw_raw  = sw;
        enter_n = 1'b0;
        repeat (hold) @(negedge CLK);
        enter_n = 1'b1;
        repeat (12) @(negedge CLK);
        model_snap    = sw;
        model_pending = 1'b1;
        check("pending_after_press", {31'd0, pending}, {31'd0, model_pending});
    endtask

    task automatic request();
        bit expect_v;
        int seen;
        expect_v = model_pending;
        seen = 0;
        if (model_pending) begin
            exp_q.push_back(extend(model_snap));
            model_pending = 1'b0;
        end
        @(negedge CLK);
        in_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (in_valid) begin
                seen++;
                if (expect_v) break;
            end
        end
        in_req = 1'b0;
        check("valid_count", seen, {31'd0, expect_v});
        check("pending_after_req", {31'd0, pending}, {31'd0, model_pending});
    endtask

    task automatic bounce(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (i % 2 == 0) enter_n = ~enter_n;
        end
        @(negedge CLK);
        enter_n = 1'b1;
        repeat (12) @(negedge CLK);
        check("pending_after_bounce", {31'd0, pending}, {31'd0, model_pending});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        repeat (3) @(negedge CLK);
        check("reset_pending", {31'd0, pending}, 32'd0);
        check("reset_in_data", in_data, 32'd0);
        reset = 1'b1;
        repeat (12) @(negedge CLK);

        // Basic press with latency measurement.
        sw_raw  = 10'h155;
        enter_n = 1'b0;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (pending && first == 0) first = c;
        end
        enter_n = 1'b1;
        model_snap = 10'h155;
        model_pending = 1'b1;
        check("press_latency", {31'd0, (first >= 7 && first <= 9)}, 32'd1);
        repeat (12) @(negedge CLK);
        request();

        // Reset mid-debounce with the key held through reset.
        @(negedge CLK);
        sw_raw  = 10'h0AA;
        enter_n = 1'b0;
        repeat (4) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("rst_in_valid", {31'd0, in_valid}, 32'd0);
        check("rst_in_data", in_data, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        model_pending = 1'b0;
        repeat (25) @(negedge CLK);
        check("held_through_reset", {31'd0, pending}, 32'd0);
        enter_n = 1'b1;
        repeat (20) @(negedge CLK);
        check("released_after_reset", {31'd0, pending}, 32'd0);
        press(10'h02A, 8);
        request();

        // Bounce rejection, then one clean 6-cycle press.
        bounce(20);
        press(10'h11E, 6);
        request();

        // Overwrite: latest press wins.
        press(10'd3, 8);
        press(10'd7, 8);
        request();
        request();

        // Press accepted on the same edge the old snapshot is consumed.
        press(10'h0C3, 8);
        @(negedge CLK);
        sw_raw  = 10'h13C;
        enter_n = 1'b0;
        repeat (7) @(negedge CLK);
        exp_q.push_back(extend(model_snap));
        in_req = 1'b1;
        @(negedge CLK);
        in_req = 1'b0;
        check("simul_valid", {31'd0, in_valid}, 32'd1);
        check("simul_pending", {31'd0, pending}, 32'd1);
        model_snap = 10'h13C;
        model_pending = 1'b1;
        repeat (4) @(negedge CLK);
        enter_n = 1'b1;
        repeat (12) @(negedge CLK);
        request();

        // Extension of the top switch bit.
        press(10'h3FF, 8);
        request();
        press(10'h200, 8);
        request();

        // Randomized mix of presses, requests and bounces.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0, 1: press(SW'($urandom_range(0, 1023)), int'($urandom_range(6, 12)));
                2:    request();
                default: bounce(int'($urandom_range(4, 12)));
            endcase
        end
        request();

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
